decoder_pulse: RTL and testbench



---
 rtl/decoder_pulse.sv | 105 ++++++++++
 tb/tb_decoder_pulse.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/decoder_pulse.sv
// Registered binary-to-one-hot decoder: each accepted code drives one output
// line for PULSE_LEN cycles, followed by a GAP_LEN-cycle all-zero gap.
module decoder_pulse #(
  parameter int CODE_W    = 3,
  parameter int OUT_W     = 2 ** CODE_W,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code,
  input  logic              enable,
  output logic [OUT_W-1:0]  out,
  output logic              busy,
  output logic              done,
  output logic [7:0]        count
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  localparam logic [7:0] PULSE_INIT = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_INIT   = 8'(GAP_LEN - 1);

  state_t             state_reg, state_next;
  logic [OUT_W-1:0]   out_reg, out_next;
  logic [7:0]         timer_reg, timer_next;
  logic               done_reg, done_next;
  logic [7:0]         count_reg, count_next;
  logic [OUT_W-1:0]   onehot;

  // Each output line compares the code against its own index, so at most one bit can be set.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_decode
      assign onehot[gi] = (code == CODE_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      timer_reg <= 8'd0;
      done_reg  <= 1'b0;
      count_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      timer_reg <= timer_next;
      done_reg  <= done_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    timer_next = timer_reg;
    done_next  = 1'b0;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        out_next = '0;
        // A disabled request is simply consumed; the block stays ready.
        if (in_valid && enable) begin
          state_next = DRIVE;
          out_next   = onehot;
          timer_next = PULSE_INIT;
        end
      end
      DRIVE: begin
        if (timer_reg == 8'd0) begin
          state_next = GAP;
          out_next   = '0;
          timer_next = GAP_INIT;
          done_next  = 1'b1;
          count_next = count_reg + 8'd1;
        end else begin
          timer_next = timer_reg - 8'd1;
        end
      end
      GAP: begin
        out_next = '0;
        if (timer_reg == 8'd0) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg - 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        out_next   = '0;
        timer_next = 8'd0;
      end
    endcase
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign out      = out_reg;
  assign done     = done_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_decoder_pulse.sv
// Directed bench for decoder_pulse with default parameters (8 outputs,
// 4-cycle pulse, 1-cycle gap); inputs change and outputs are sampled on negedge.
module tb_decoder_pulse;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] code;
  logic       enable;
  logic [7:0] out;
  logic       busy;
  logic       done;
  logic [7:0] count;

  int         checks;
  int         failures;
  logic [7:0] exp_count;

  decoder_pulse dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .code     (code),
    .enable   (enable),
    .out      (out),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue an enabled request and follow it through DRIVE, GAP and back to IDLE.
  // mid_c is placed on code during the pulse; keep leaves in_valid asserted.
  task automatic pulse(input logic [2:0] c, input logic [2:0] mid_c, input logic keep);
    logic [7:0] exp_out;
    exp_out  = 8'h01 << c;
    in_valid = 1'b1;
    code     = c;
    enable   = 1'b1;
    @(negedge clk);
    code = mid_c;
    if (!keep) in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("drive_out", out, exp_out);
      check("drive_busy", busy, 1'b1);
      check("drive_ready", in_ready, 1'b0);
      check("drive_done", done, 1'b0);
      @(negedge clk);
    end
    exp_count++;
    check("gap_out", out, 8'h00);
    check("gap_done", done, 1'b1);
    check("gap_ready", in_ready, 1'b0);
    check("gap_count", count, exp_count);
    @(negedge clk);
    check("idle_out", out, 8'h00);
    check("idle_done", done, 1'b0);
    check("idle_ready", in_ready, 1'b1);
    $display("txn code=%0d out=%02h count=%0d", c, exp_out, exp_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    exp_count = 8'd0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    code      = 3'd0;
    enable    = 1'b0;

    // Reset held for two cycles.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_out", out, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_count", count, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    @(negedge clk);

    // Single request; code wiggled during the pulse must not matter.
    pulse(3'd3, 3'd5, 1'b0);

    // in_valid held high, code stepped on every accept.
    for (int c = 0; c < 8; c++) pulse(3'(c), 3'(c), 1'b1);
    in_valid = 1'b0;
    check("step_count", count, 8'd9);

    // Disabled request is consumed silently.
    in_valid = 1'b1;
    code     = 3'd7;
    enable   = 1'b0;
    @(negedge clk);
    check("dis_out", out, 8'h00);
    check("dis_ready", in_ready, 1'b1);
    check("dis_busy", busy, 1'b0);
    check("dis_done", done, 1'b0);
    check("dis_count", count, exp_count);
    in_valid = 1'b0;
    @(negedge clk);
    check("dis_out2", out, 8'h00);
    $display("txn code=7 enable=0 out=00 count=%0d", exp_count);
    pulse(3'd7, 3'd7, 1'b0);

    // Pending 110 request during the 001 pulse is served only after the gap.
    pulse(3'd1, 3'd6, 1'b1);
    pulse(3'd6, 3'd6, 1'b0);

    // Reset in the second DRIVE cycle aborts the pulse.
    in_valid = 1'b1;
    code     = 3'd5;
    enable   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_out1", out, 8'h20);
    @(negedge clk);
    check("abort_out2", out, 8'h20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_count = 8'd0;
    check("abort_out", out, 8'h00);
    check("abort_count", count, 8'd0);
    check("abort_done", done, 1'b0);
    check("abort_ready", in_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    $display("txn code=5 reset mid-pulse out=00 count=0");
    @(negedge clk);
    check("abort_done2", done, 1'b0);

    // 256 enabled requests: count wraps back to zero.
    for (int i = 0; i < 256; i++) pulse(3'(i), 3'(i + 1), 1'b0);
    check("wrap_count", count, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
